// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/execute/writeback
// over a shared instruction/data memory that can stretch accesses via
// mem_ready. Datapath controls are decoded combinationally from the state.
//
//   state   | code | meaning
//   FETCH   |  0   | read instruction at PC, PC+4 -> PC when memory completes
//   DECODE  |  1   | read registers, precompute branch target in ALUOut
//   MEMADR  |  2   | effective address = rs + signimm
//   MEMRD   |  3   | data read from ALUOut address, held until memory completes
//   MEMWB   |  4   | loaded data -> rt
//   MEMWR   |  5   | data write to ALUOut address, held until memory completes
//   RTYPEEX |  6   | ALU op selected by funct
//   RTYPEWB |  7   | ALU result -> rd (suppressed for unsupported funct)
//   BEQEX   |  8   | compare rs/rt, take branch target when equal
//   ADDIEX  |  9   | rs + signimm
//   ADDIWB  | 10   | ALU result -> rt
//   JEX     | 11   | jump target -> PC
module mips_mc_controller #(
   parameter int FETCH_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcen,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic [3:0] state,
   output logic       illegal_op
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_e     state_q, state_d;
   logic       bad_funct_q, bad_funct_d;
   logic       ready_eff;
   logic       funct_ok;
   logic [2:0] funct_alu;

   assign ready_eff = (FETCH_WAIT == 0) ? 1'b1 : mem_ready;
   assign state     = state_q;

   // R-type funct decode, shared by the execute cycle and the writeback gate
   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = 3'b010;
      case (funct)
         6'b100000: funct_alu = 3'b010;
         6'b100010: funct_alu = 3'b110;
         6'b100100: funct_alu = 3'b000;
         6'b100101: funct_alu = 3'b001;
         6'b101010: funct_alu = 3'b111;
         default:   funct_ok  = 1'b0;
      endcase
   end

   // Remember an unsupported funct seen in RTYPEEX so RTYPEWB can drop the write
   assign bad_funct_d = (state_q == S_RTYPEEX) ? ~funct_ok : bad_funct_q;

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_FETCH;
         bad_funct_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bad_funct_q <= bad_funct_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:   state_d = ready_eff ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_d = ready_eff ? S_MEMWB : S_MEMRD;
         S_MEMWR:   state_d = ready_eff ? S_FETCH : S_MEMWR;
         S_RTYPEEX: state_d = S_RTYPEWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         default:   state_d = S_FETCH;
      endcase
   end

   // Output decode: everything defaults low, each state raises only its own controls
   always_comb begin
      pcen       = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b000;
      illegal_op = 1'b0;
      case (state_q)
         S_FETCH: begin
            alusrcb    = 2'b01;
            alucontrol = 3'b010;
            irwrite    = ready_eff;
            pcen       = ready_eff;
         end
         S_DECODE: begin
            alusrcb    = 2'b11;
            alucontrol = 3'b010;
            case (op)
               OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
               default:                                      illegal_op = 1'b1;
            endcase
         end
         S_MEMADR, S_ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alucontrol = 3'b010;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            alusrca    = 1'b1;
            alucontrol = funct_alu;
            illegal_op = ~funct_ok;
         end
         S_RTYPEWB: begin
            regdst   = 1'b1;
            regwrite = ~bad_funct_q;
         end
         S_BEQEX: begin
            alusrca    = 1'b1;
            alucontrol = 3'b110;
            pcsrc      = 2'b01;
            pcen       = zero;
         end
         S_ADDIWB: regwrite = 1'b1;
         S_JEX: begin
            pcsrc = 2'b10;
            pcen  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: directed scenarios with literal expectations,
// then random instruction streams checked against an instruction-level model.
module tb_mips_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero, mem_ready;
   logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;
   logic       illegal_op;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mips_mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .memwrite(memwrite),
      .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
      .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
      .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state),
      .illegal_op(illegal_op)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- instruction-level reference model ----------------
   function automatic bit legal_op(input logic [5:0] o);
      return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
   endfunction

   function automatic bit legal_funct(input logic [5:0] f);
      return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,illegal_op}
   function automatic logic [15:0] model_out(input int ph, input logic mr, input logic z,
                                              input logic [5:0] o, input logic [5:0] f);
      case (ph)
         0:  return {mr, 1'b0, 1'b0, mr, 4'b0000, 2'b01, 2'b00, 3'b010, 1'b0};
         1:  return {8'b0, 2'b11, 2'b00, 3'b010, ~legal_op(o)};
         2, 9: return {7'b0, 1'b1, 2'b10, 2'b00, 3'b010, 1'b0};
         3:  return {1'b0, 1'b1, 14'b0};
         4:  return {5'b0, 1'b1, 1'b1, 9'b0};
         5:  return {1'b0, 1'b1, 1'b1, 13'b0};
         6:  return {7'b0, 1'b1, 2'b00, 2'b00, alu_of(f), ~legal_funct(f)};
         7:  return {4'b0, 1'b1, 1'b0, legal_funct(f), 9'b0};
         8:  return {z, 6'b0, 1'b1, 2'b00, 2'b01, 3'b110, 1'b0};
         10: return {6'b0, 1'b1, 9'b0};
         11: return {z & 1'b0 | 1'b1, 6'b0, 1'b0, 2'b00, 2'b10, 3'b000, 1'b0};
         default: return 16'h0;
      endcase
   endfunction

   function automatic logic [15:0] dut_vec();
      return {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
              alusrcb, pcsrc, alucontrol, illegal_op};
   endfunction

   // One cycle of the random run: drive, compare against model at negedge, advance
   task automatic rnd_cycle(input int ph, input int waited, output bit adv);
      mem_ready = (waited >= 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
      zero      = $urandom_range(0, 1);
      @(negedge clk);
      chk("rnd_state", {28'b0, state}, ph);
      chk("rnd_outputs", {16'b0, dut_vec()}, {16'b0, model_out(ph, mem_ready, zero, op, funct)});
      adv = !(ph == 0 || ph == 3 || ph == 5) || mem_ready;
      step();
   endtask

   // Hard time limit so a stuck DUT never hangs the run
   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
      $fatal(1, "timeout");
   end

   int exp_st[6];
   int exp_rw[6];
   int wcount;

   initial begin
      op = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b0;
      reset = 1'b0;
      #12;
      // reset holds FETCH, outputs gated by mem_ready
      chk("reset_state", {28'b0, state}, 0);
      chk("reset_pcen_low", {31'b0, pcen}, 0);
      mem_ready = 1'b1;
      #1;
      chk("reset_irwrite_mr", {31'b0, irwrite}, 1);
      mem_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      step();
      step();
      chk("no_advance_without_ready", {28'b0, state}, 0);

      // lw with ready tied high: 0,1,2,3,4,0
      exp_st = '{0, 1, 2, 3, 4, 0};
      exp_rw = '{0, 0, 0, 0, 1, 0};
      op = 6'b100011; mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("lw_state", {28'b0, state}, exp_st[i]);
         chk("lw_regwrite", {31'b0, regwrite}, exp_rw[i]);
         chk("lw_memtoreg", {31'b0, memtoreg}, exp_rw[i]);
         if (i < 5) step();
      end

      // sw with three wait cycles in MEMWR
      op = 6'b101011;
      step(); step(); step();
      wcount = 0;
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("sw_hold_state", {28'b0, state}, 5);
         if (memwrite) wcount++;
         step();
      end
      mem_ready = 1'b1;
      if (memwrite) wcount++;
      chk("sw_state_last", {28'b0, state}, 5);
      chk("sw_memwrite_cycles", wcount, 4);
      step();
      chk("sw_back_fetch", {28'b0, state}, 0);

      // R-type slt, then unsupported funct
      op = 6'b000000; funct = 6'b101010;
      step(); step();
      chk("slt_ex_state", {28'b0, state}, 6);
      chk("slt_alucontrol", {29'b0, alucontrol}, 3'b111);
      step();
      chk("slt_wb_regdst", {31'b0, regdst}, 1);
      chk("slt_wb_regwrite", {31'b0, regwrite}, 1);
      step();
      funct = 6'b111111;
      step(); step();
      chk("badfunct_illegal", {31'b0, illegal_op}, 1);
      step();
      chk("badfunct_wb_state", {28'b0, state}, 7);
      chk("badfunct_illegal_once", {31'b0, illegal_op}, 0);
      chk("badfunct_no_regwrite", {31'b0, regwrite}, 0);
      step();

      // beq taken / not taken
      op = 6'b000100; zero = 1'b1;
      step(); step();
      chk("beq_taken_pcen", {31'b0, pcen}, 1);
      chk("beq_pcsrc", {30'b0, pcsrc}, 2'b01);
      step();
      zero = 1'b0;
      step(); step();
      chk("beq_not_taken_pcen", {31'b0, pcen}, 0);
      step();

      // unsupported opcode
      op = 6'b111111;
      step();
      chk("badop_illegal", {31'b0, illegal_op}, 1);
      chk("badop_no_write", {30'b0, regwrite, memwrite}, 0);
      step();
      chk("badop_to_fetch", {28'b0, state}, 0);

      // async reset while waiting in MEMRD
      op = 6'b100011;
      step(); step(); step();
      mem_ready = 1'b0;
      step();
      chk("memrd_wait_state", {28'b0, state}, 3);
      #2 reset = 1'b0;
      #1;
      chk("async_reset_state", {28'b0, state}, 0);
      chk("async_reset_memwrite", {31'b0, memwrite}, 0);
      chk("async_reset_regwrite", {31'b0, regwrite}, 0);
      #1 reset = 1'b1;
      step();
      chk("post_reset_hold", {28'b0, state}, 0);

      // random instruction stream
      for (int n = 0; n < 400; n++) begin
         int q[$];
         int kind;
         kind = $urandom_range(0, 6);
         funct = 6'($urandom_range(0, 63));
         case (kind)
            0: begin op = 6'b100011; q = '{0, 1, 2, 3, 4}; end
            1: begin op = 6'b101011; q = '{0, 1, 2, 5}; end
            2: begin
               op = 6'b000000; q = '{0, 1, 6, 7};
               if ($urandom_range(0, 3) != 0) begin
                  case ($urandom_range(0, 4))
                     0: funct = 6'b100000;
                     1: funct = 6'b100010;
                     2: funct = 6'b100100;
                     3: funct = 6'b100101;
                     default: funct = 6'b101010;
                  endcase
               end
            end
            3: begin op = 6'b000100; q = '{0, 1, 8}; end
            4: begin op = 6'b001000; q = '{0, 1, 9, 10}; end
            5: begin op = 6'b000010; q = '{0, 1, 11}; end
            default: begin
               op = 6'($urandom_range(0, 63));
               while (legal_op(op)) op = 6'($urandom_range(0, 63));
               q = '{0, 1};
            end
         endcase
         foreach (q[k]) begin
            bit adv;
            int waited;
            adv = 1'b0;
            waited = 0;
            while (!adv) begin
               rnd_cycle(q[k], waited, adv);
               waited++;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
